rr_decoder_arbiter: RTL
=======================

Name: rr_decoder_arbiter

Overview:
Round-robin arbiter that shares one 2-to-4 decoded select resource among four requesters. It picks one requester and drives the encoded index plus its one-hot decoded grant. It holds the grant until the requester releases it or a hold timeout expires. It sits between requesting masters and the decoder-selected shared resource.

Parameters:
HOLD_MAX, 8, maximum cycles a grant may be held before forced release (legal range 2..15).
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
req  input  4  request per requester; req[i] is held high while requester i wants the resource
done  input  1  the current grant holder releases the resource; sampled only in GRANT
gnt  output  4  registered one-hot grant; gnt[i] = gnt_valid AND (gnt_idx == i)
gnt_idx  output  2  registered encoded index of the granted requester
gnt_valid  output  1  high while a grant is active
timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX

Behaviour:
- Single clock domain (clk). rst is asynchronous and active-high. Assertion of rst immediately forces every output and all state to reset values, independent of clk.
- Reset values: state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, hold counter=0, last=2'b11. With last=3, requester 0 has top priority after reset.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise select the first set req bit in the search order last+1, last+2, last+3, last+4 (all mod 4).
  - At the next edge: load gnt_idx with the selected index, set gnt_valid=1, clear the counter, go to GRANT.
  - Latency: gnt is asserted on the first edge after req is sampled high in IDLE.
- GRANT:
  - The counter increments each cycle.
  - Release condition A: done=1, or req[gnt_idx]=0.
  - Release condition B: counter == HOLD_MAX-1.
  - If A or B holds: go to RELEASE, clear gnt_valid and gnt, set last=gnt_idx.
  - timeout pulses high for exactly one cycle (the cycle gnt drops) only if B holds and A does not. done takes precedence over timeout.
  - gnt_idx keeps its value after release; only gnt_valid qualifies it.
  - Maximum grant length is HOLD_MAX cycles.
- RELEASE:
  - One dead cycle with gnt=0, then unconditionally go to IDLE.
  - The minimum gap between consecutive grants is 2 cycles (RELEASE, then IDLE arbitration).
- Fairness:
  - A requester that has just been served has lowest priority in the next arbitration.
  - Every continuously requesting requester is granted within 3 intervening grants.
- Boundary rules:
  - done outside GRANT is ignored.
  - req changes on non-granted bits during GRANT are ignored.
  - last wraps from 3 to 0.
  - gnt is never multi-hot and never active outside GRANT.

Test Plan:
- Reset priority: assert rst, release; req=4'b1010 -> one edge later gnt=4'b0010, gnt_idx=1, gnt_valid=1.
- Round robin: req=4'b1111 held, done pulsed one cycle into each grant -> grant order 0,1,2,3,0, with gnt=0 for 2 cycles between grants.
- Timeout: HOLD_MAX=8, req=4'b0100 held, done=0 -> gnt=4'b0100 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=4'b0100 again after the 2-cycle gap.
- done/timeout collision: done asserted in the cycle the counter equals 7 -> gnt drops and timeout stays 0.
- Request drop: grant requester 2, deassert req[2] mid-grant with req[3]=1 -> release, then gnt=4'b1000 two cycles later.
- Async reset mid-grant: during gnt=4'b0001, assert rst between clk edges -> gnt, gnt_valid and timeout go to 0 immediately. After release, req=4'b1000 -> gnt=4'b1000.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter that grants one of four requesters a shared, decoder-selected resource.
// A grant lasts until the holder releases it or HOLD_MAX cycles pass, then one dead cycle follows.
module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       pick;
    logic             pick_ok;
    logic             rel_a;
    logic             rel_b;

    // Search starts just after the last served requester, so it ends up lowest priority.
    always_comb begin
        pick    = 2'd0;
        pick_ok = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_ok && req[2'(last_q + 2'(k))]) begin
                pick    = 2'(last_q + 2'(k));
                pick_ok = 1'b1;
            end
        end
    end

    assign rel_a = done || !req[gnt_idx_q];
    assign rel_b = (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        gnt_d       = gnt_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    gnt_idx_d   = pick;
                    gnt_valid_d = 1'b1;
                    gnt_d       = 4'b0001 << pick;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                // A voluntary release wins over the timeout when both happen together.
                if (rel_a || rel_b) begin
                    state_d     = RELEASE;
                    gnt_valid_d = 1'b0;
                    gnt_d       = 4'b0000;
                    last_d      = gnt_idx_q;
                    timeout_d   = rel_b && !rel_a;
                end
            end
            RELEASE: begin
                gnt_valid_d = 1'b0;
                gnt_d       = 4'b0000;
                state_d     = IDLE;
            end
            default: begin
                gnt_valid_d = 1'b0;
                gnt_d       = 4'b0000;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= 2'b00;
            last_q      <= 2'b11;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
